i2s_tx_sample_fifo: RTL

- Stereo sample FIFO sitting directly upstream of the I2S transmit/receive block. It feeds that block's parallel l_in/r_in inputs.
- It absorbs samples from the rxadc decimator output, which arrive bursty and on their own schedule.
- It releases one stereo pair per I2S frame, on that block's per-frame valid strobe.
- It provides prefill, mute-on-underrun recovery, and level and error reporting for the host register interface.

---
 rtl/i2s_tx_sample_fifo_if.sv | 22 ++
 rtl/i2s_tx_sample_fifo.sv | 118 +++++++++++
 2 files changed

// File: rtl/i2s_tx_sample_fifo_if.sv
// rtl/i2s_tx_sample_fifo_if.sv - sample write stream and per-frame read/output bundle for the I2S sample FIFO
interface i2s_tx_sample_fifo_if;
    logic [15:0] wr_l;
    logic [15:0] wr_r;
    logic        wr_valid;
    logic        wr_ready;
    logic        rd_strobe;
    logic [15:0] l_in;
    logic [15:0] r_in;

    // Producer/consumer side: decimator writes, I2S block strobes and reads
    modport master (
        output wr_l, wr_r, wr_valid, rd_strobe,
        input  wr_ready, l_in, r_in
    );

    // FIFO side
    modport slave (
        input  wr_l, wr_r, wr_valid, rd_strobe,
        output wr_ready, l_in, r_in
    );
endinterface

// File: rtl/i2s_tx_sample_fifo.sv
// rtl/i2s_tx_sample_fifo.sv - stereo sample FIFO with prefill and mute-on-underrun feeding the I2S transmitter
module i2s_tx_sample_fifo #(
    parameter int DEPTH_LOG2 = 5,
    parameter int PREFILL    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clr_flags,
    i2s_tx_sample_fifo_if.slave   bus,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  running,
    output logic                  underrun,
    output logic                  overrun
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]         FULL_LEVEL    = LW'(DEPTH);
    localparam logic [LW-1:0]         PREFILL_LEVEL = LW'(PREFILL);
    localparam logic [LW-1:0]         LEVEL_ZERO    = '0;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE       = DEPTH_LOG2'(1);

    typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_t;

    state_t                 state;
    logic [31:0]            mem [DEPTH];
    logic [31:0]            rd_data;
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [15:0]            l_q;
    logic [15:0]            r_q;
    logic                   pend;
    logic                   push;
    logic                   pop;
    logic                   under_evt;
    logic                   over_evt;

    assign bus.wr_ready = (level != FULL_LEVEL);
    assign bus.l_in     = l_q;
    assign bus.r_in     = r_q;
    assign running      = (state == S_RUN);

    // flush swallows any same-cycle write or pop, so neither counts as an event
    assign push      = ~flush & bus.wr_valid & bus.wr_ready;
    assign over_evt  = ~flush & bus.wr_valid & ~bus.wr_ready;
    assign pop       = ~flush & (state == S_RUN) & bus.rd_strobe & (level != LEVEL_ZERO);
    assign under_evt = ~flush & (state == S_RUN) & bus.rd_strobe & (level == LEVEL_ZERO);

    // Sample storage write port, left in the upper half of each word
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.wr_l, bus.wr_r};
    end

    // Registered read of the head pair on a pop
    always_ff @(posedge clk) begin
        if (pop)
            rd_data <= mem[rd_ptr];
    end

    // Pointers, level, playout state, output registers and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            l_q      <= '0;
            r_q      <= '0;
            pend     <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (flush) begin
                state  <= S_FILL;
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                l_q    <= '0;
                r_q    <= '0;
                pend   <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
                level <= level + LW'(push) - LW'(pop);
                pend  <= pop;
                // second stage of a pop: RAM data reaches the I2S inputs
                if (pend) begin
                    l_q <= rd_data[31:16];
                    r_q <= rd_data[15:0];
                end
                // a mute written here overrides any pair still in flight
                case (state)
                    S_FILL: begin
                        if (bus.rd_strobe) begin
                            l_q <= '0;
                            r_q <= '0;
                        end
                        if (level >= PREFILL_LEVEL)
                            state <= S_RUN;
                    end
                    S_RUN: begin
                        if (under_evt) begin
                            l_q   <= '0;
                            r_q   <= '0;
                            state <= S_FILL;
                        end
                    end
                    default: state <= S_FILL;
                endcase
            end
            underrun <= under_evt | (underrun & ~clr_flags);
            overrun  <= over_evt  | (overrun  & ~clr_flags);
        end
    end
endmodule
